// File: rtl/jtag_dmi_pkg.sv
`timescale 1ns/1ps
// DMI request/response types shared by the JTAG DTM side and the DMI arbiter.
// Widths follow the RISC-V debug spec defaults: 7-bit address and 32-bit data.
// The arbiter adds its state encoding and the failed-response code used on watchdog expiry.
package jtag_dmi_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_OK   = 2'd0,
    DMI_RESP_RSVD = 2'd1,
    DMI_RESP_ERR  = 2'd2,
    DMI_RESP_BUSY = 2'd3
  } dmi_resp_e;

  // Response code reported to a requester whose transaction was killed by the watchdog.
  localparam logic [1:0] DMI_RESP_FAILED = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } dmi_arb_state_e;

endpackage

// File: rtl/jtag_dmi_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin arbiter in front of the single Debug Module DMI port, with hang watchdog.
// Latency: accept in cycle 0, DMI request from cycle 1, response pulse one cycle after dmi_rsp_valid.
// Backpressure: one transaction outstanding; mN_req_ready only in IDLE, DMI payload held until dmi_req_ready.
module jtag_dmi_arbiter
  import jtag_dmi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // requester 0 (JTAG DTM)
  input  logic                      m0_req_valid,
  output logic                      m0_req_ready,
  input  logic [DMI_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DMI_DATA_WIDTH-1:0] m0_wdata,
  input  dmi_op_e                   m0_op,
  output logic                      m0_rsp_valid,
  output logic [DMI_DATA_WIDTH-1:0] m0_rdata,
  output dmi_resp_e                 m0_resp,
  // requester 1 (secondary debug host)
  input  logic                      m1_req_valid,
  output logic                      m1_req_ready,
  input  logic [DMI_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DMI_DATA_WIDTH-1:0] m1_wdata,
  input  dmi_op_e                   m1_op,
  output logic                      m1_rsp_valid,
  output logic [DMI_DATA_WIDTH-1:0] m1_rdata,
  output dmi_resp_e                 m1_resp,
  // Debug Module side
  output logic                      dmi_req_valid,
  input  logic                      dmi_req_ready,
  output logic [DMI_ADDR_WIDTH-1:0] dmi_addr,
  output logic [DMI_DATA_WIDTH-1:0] dmi_wdata,
  output dmi_op_e                   dmi_op,
  input  logic                      dmi_rsp_valid,
  input  logic [DMI_DATA_WIDTH-1:0] dmi_rdata,
  input  dmi_resp_e                 dmi_resp,
  output logic                      dmi_abort,
  // status
  output logic                      busy,
  output logic                      grant_id,
  output logic [7:0]                timeout_count
);

  // A zero timeout disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam int             CNT_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  dmi_arb_state_e            state_q, state_d;
  logic                      rr_pref_q, rr_pref_d;
  logic                      grant_id_q, grant_id_d;
  logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  dmi_op_e                   op_q, op_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                tmo_cnt_q, tmo_cnt_d;
  logic                      abort_q, abort_d;
  logic                      rsp0_vld_q, rsp0_vld_d;
  logic [DMI_DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  dmi_resp_e                 resp0_q, resp0_d;
  logic                      rsp1_vld_q, rsp1_vld_d;
  logic [DMI_DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  dmi_resp_e                 resp1_q, resp1_d;

  logic pick1;
  logic req_done;
  logic rsp_done;
  logic expire;

  // Arbitration, FSM next state, watchdog and response routing.
  always_comb begin
    state_d      = state_q;
    rr_pref_d    = rr_pref_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    abort_d      = 1'b0;
    rsp0_vld_d   = 1'b0;
    rdata0_d     = rdata0_q;
    resp0_d      = resp0_q;
    rsp1_vld_d   = 1'b0;
    rdata1_d     = rdata1_q;
    resp1_d      = resp1_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;

    // Requester 1 wins when it is alone, or when both ask and it holds the preference.
    pick1    = m1_req_valid & (~m0_req_valid | rr_pref_q);
    req_done = (state_q == REQ) && dmi_req_ready;
    rsp_done = (state_q == RSP) && dmi_rsp_valid;
    // Completion in the expiry cycle takes priority over the timeout.
    expire   = WD_EN && (state_q != IDLE) && (cnt_q == CNT_LAST) && !req_done && !rsp_done;

    if (WD_EN && (state_q != IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          m0_req_ready = ~pick1;
          m1_req_ready = pick1;
          grant_id_d   = pick1;
          rr_pref_d    = ~pick1;
          addr_d       = pick1 ? m1_addr  : m0_addr;
          wdata_d      = pick1 ? m1_wdata : m0_wdata;
          op_d         = pick1 ? m1_op    : m0_op;
          cnt_d        = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        // Any response seen here is spurious and dropped.
        if (req_done) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_done) begin
          state_d = IDLE;
          if (grant_id_q) begin
            rsp1_vld_d = 1'b1;
            rdata1_d   = dmi_rdata;
            resp1_d    = dmi_resp;
          end else begin
            rsp0_vld_d = 1'b1;
            rdata0_d   = dmi_rdata;
            resp0_d    = dmi_resp;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (expire) begin
      state_d = IDLE;
      abort_d = 1'b1;
      if (tmo_cnt_q != 8'hFF) begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      if (grant_id_q) begin
        rsp1_vld_d = 1'b1;
        rdata1_d   = '0;
        resp1_d    = dmi_resp_e'(DMI_RESP_FAILED);
      end else begin
        rsp0_vld_d = 1'b1;
        rdata0_d   = '0;
        resp0_d    = dmi_resp_e'(DMI_RESP_FAILED);
      end
    end
  end

  // State and output registers; reset drops everything, including any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_pref_q  <= 1'b0;
      grant_id_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= DMI_OP_NOP;
      cnt_q      <= '0;
      tmo_cnt_q  <= '0;
      abort_q    <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rdata0_q   <= '0;
      resp0_q    <= DMI_RESP_OK;
      rsp1_vld_q <= 1'b0;
      rdata1_q   <= '0;
      resp1_q    <= DMI_RESP_OK;
    end else begin
      state_q    <= state_d;
      rr_pref_q  <= rr_pref_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      abort_q    <= abort_d;
      rsp0_vld_q <= rsp0_vld_d;
      rdata0_q   <= rdata0_d;
      resp0_q    <= resp0_d;
      rsp1_vld_q <= rsp1_vld_d;
      rdata1_q   <= rdata1_d;
      resp1_q    <= resp1_d;
    end
  end

  assign dmi_req_valid = (state_q == REQ);
  assign dmi_addr      = addr_q;
  assign dmi_wdata     = wdata_q;
  assign dmi_op        = op_q;
  assign dmi_abort     = abort_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_id_q;
  assign timeout_count = tmo_cnt_q;
  assign m0_rsp_valid  = rsp0_vld_q;
  assign m0_rdata      = rdata0_q;
  assign m0_resp       = resp0_q;
  assign m1_rsp_valid  = rsp1_vld_q;
  assign m1_rdata      = rdata1_q;
  assign m1_resp       = resp1_q;

endmodule

// File: tb/tb_jtag_dmi_arbiter.sv
`timescale 1ns/1ps
// Directed bench for jtag_dmi_arbiter: table of single transactions plus hand-written
// timeout, completion-vs-timeout and mid-transaction reset sequences.
module tb_jtag_dmi_arbiter;
  import jtag_dmi_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      m0_req_valid, m1_req_valid;
  logic                      m0_req_ready, m1_req_ready;
  logic [DMI_ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [DMI_DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  dmi_op_e                   m0_op, m1_op;
  logic                      m0_rsp_valid, m1_rsp_valid;
  logic [DMI_DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  dmi_resp_e                 m0_resp, m1_resp;
  logic                      dmi_req_valid, dmi_req_ready;
  logic [DMI_ADDR_WIDTH-1:0] dmi_addr;
  logic [DMI_DATA_WIDTH-1:0] dmi_wdata;
  dmi_op_e                   dmi_op;
  logic                      dmi_rsp_valid;
  logic [DMI_DATA_WIDTH-1:0] dmi_rdata;
  dmi_resp_e                 dmi_resp;
  logic                      dmi_abort;
  logic                      busy;
  logic                      grant_id;
  logic [7:0]                timeout_count;

  jtag_dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_op(m0_op), .m0_rsp_valid(m0_rsp_valid),
    .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_op(m1_op), .m1_rsp_valid(m1_rsp_valid),
    .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_op(dmi_op), .dmi_rsp_valid(dmi_rsp_valid),
    .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp), .dmi_abort(dmi_abort),
    .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [6:0]  a0;
    logic [6:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  op;
    int          rdly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        gnt;
  } vec_t;

  vec_t        vecs [8];
  int          n_pass;
  int          n_total;
  logic [31:0] exp_rd [2];
  logic [1:0]  exp_rs [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    vec_t v;
    n_pass  = 0;
    n_total = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_rs[0] = '0; exp_rs[1] = '0;

    //            v0 v1  a0     a1     wd0           wd1           op   rdly rdata         resp gnt
    vecs[0] = '{1'b1, 1'b0, 7'h11, 7'h00, 32'h0,        32'h0,        2'd1, 0, 32'hDEADBEEF, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 7'h00, 7'h22, 32'h0,        32'h12345678, 2'd2, 0, 32'h00000000, 2'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 7'h20, 7'h30, 32'h0,        32'h0,        2'd1, 0, 32'hA0000020, 2'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 7'h20, 7'h30, 32'h0,        32'h0,        2'd1, 0, 32'hB0000030, 2'd0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 7'h20, 7'h30, 32'h0,        32'h0,        2'd1, 1, 32'hA0000020, 2'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 7'h20, 7'h30, 32'h0,        32'h0,        2'd1, 0, 32'hB0000030, 2'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 7'h05, 7'h00, 32'hCAFEF00D, 32'h0,        2'd2, 5, 32'h00000000, 2'd0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 7'h00, 7'h00, 32'h0,        32'h0,        2'd0, 2, 32'h00000000, 2'd3, 1'b1};

    rst_n = 1'b0;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_op = DMI_OP_NOP; m1_op = DMI_OP_NOP;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rdata = '0; dmi_resp = DMI_RESP_OK;

    repeat (2) @(negedge clk);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_grant",     32'(grant_id), 32'd0);
    chk("rst_dmi_vld",   32'(dmi_req_valid), 32'd0);
    chk("rst_dmi_addr",  32'(dmi_addr), 32'd0);
    chk("rst_tmo",       32'(timeout_count), 32'd0);
    chk("rst_abort",     32'(dmi_abort), 32'd0);
    chk("rst_rsp0",      32'(m0_rsp_valid), 32'd0);
    chk("rst_rdata1",    m1_rdata, 32'd0);
    rst_n = 1'b1;

    // Table: each entry is one full transaction, starting at a negedge with the DUT idle.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      m0_req_valid = v.v0; m1_req_valid = v.v1;
      m0_addr = v.a0; m1_addr = v.a1;
      m0_wdata = v.wd0; m1_wdata = v.wd1;
      m0_op = dmi_op_e'(v.op); m1_op = dmi_op_e'(v.op);
      #1;
      chk("accept_rdy0", 32'(m0_req_ready), 32'(v.gnt == 1'b0));
      chk("accept_rdy1", 32'(m1_req_ready), 32'(v.gnt == 1'b1));
      @(negedge clk);
      chk("grant_id",    32'(grant_id), 32'(v.gnt));
      chk("dmi_vld",     32'(dmi_req_valid), 32'd1);
      chk("dmi_addr",    32'(dmi_addr), 32'(v.gnt ? v.a1 : v.a0));
      chk("dmi_wdata",   dmi_wdata, v.gnt ? v.wd1 : v.wd0);
      chk("dmi_op",      32'(dmi_op), 32'(v.op));
      chk("busy_rdy0",   32'(m0_req_ready), 32'd0);
      for (int k = 0; k < v.rdly; k++) begin
        @(negedge clk);
        chk("stall_vld",   32'(dmi_req_valid), 32'd1);
        chk("stall_addr",  32'(dmi_addr), 32'(v.gnt ? v.a1 : v.a0));
        chk("stall_wdata", dmi_wdata, v.gnt ? v.wd1 : v.wd0);
        chk("stall_op",    32'(dmi_op), 32'(v.op));
        chk("stall_rdy",   32'(m0_req_ready | m1_req_ready), 32'd0);
      end
      dmi_req_ready = 1'b1;
      @(negedge clk);
      dmi_req_ready = 1'b0;
      chk("rsp_wait_vld", 32'(dmi_req_valid), 32'd0);
      dmi_rsp_valid = 1'b1; dmi_rdata = v.rdata; dmi_resp = dmi_resp_e'(v.resp);
      @(negedge clk);
      dmi_rsp_valid = 1'b0;
      exp_rd[v.gnt] = v.rdata;
      exp_rs[v.gnt] = v.resp;
      chk("rsp_vld0",  32'(m0_rsp_valid), 32'(v.gnt == 1'b0));
      chk("rsp_vld1",  32'(m1_rsp_valid), 32'(v.gnt == 1'b1));
      chk("rdata0",    m0_rdata, exp_rd[0]);
      chk("rdata1",    m1_rdata, exp_rd[1]);
      chk("resp0",     32'(m0_resp), 32'(exp_rs[0]));
      chk("resp1",     32'(m1_resp), 32'(exp_rs[1]));
      chk("done_busy", 32'(busy), 32'd0);
      chk("no_abort",  32'(dmi_abort), 32'd0);
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;

    // Watchdog: target accepts but never responds; failure reported after the 8th cycle.
    m0_req_valid = 1'b1; m0_addr = 7'h07; m0_op = DMI_OP_READ;
    @(negedge clk);
    m0_req_valid = 1'b0; dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      if (c > 2) @(negedge clk);
      chk("tmo_busy",  32'(busy), 32'd1);
      chk("tmo_early", 32'(dmi_abort | m0_rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("tmo_rsp_vld", 32'(m0_rsp_valid), 32'd1);
    chk("tmo_rdata",   m0_rdata, 32'd0);
    chk("tmo_resp",    32'(m0_resp), 32'd2);
    chk("tmo_abort",   32'(dmi_abort), 32'd1);
    chk("tmo_count",   32'(timeout_count), 32'd1);
    chk("tmo_busy_lo", 32'(busy), 32'd0);
    chk("tmo_rdata1",  m1_rdata, exp_rd[1]);

    // Response lands exactly in the expiry cycle: completion must win.
    m1_req_valid = 1'b1; m1_addr = 7'h09; m1_op = DMI_OP_READ;
    @(negedge clk);
    m1_req_valid = 1'b0; dmi_req_ready = 1'b1;
    chk("abort_pulse", 32'(dmi_abort), 32'd0);
    @(negedge clk);
    dmi_req_ready = 1'b0;
    repeat (6) @(negedge clk);
    dmi_rsp_valid = 1'b1; dmi_rdata = 32'h55AA55AA; dmi_resp = DMI_RESP_OK;
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    chk("race_vld1",  32'(m1_rsp_valid), 32'd1);
    chk("race_rdata", m1_rdata, 32'h55AA55AA);
    chk("race_resp",  32'(m1_resp), 32'd0);
    chk("race_abort", 32'(dmi_abort), 32'd0);
    chk("race_count", 32'(timeout_count), 32'd1);
    chk("race_resp0", 32'(m0_resp), 32'd2);

    // Reset while in RSP: outputs clear without a clock edge, no response afterwards.
    m0_req_valid = 1'b1; m0_addr = 7'h03; m0_op = DMI_OP_READ;
    @(negedge clk);
    m0_req_valid = 1'b0; dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    dmi_rsp_valid = 1'b1; dmi_rdata = 32'h00000001;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_addr",  32'(dmi_addr), 32'd0);
    chk("arst_tmo",   32'(timeout_count), 32'd0);
    chk("arst_rd1",   m1_rdata, 32'd0);
    chk("arst_resp0", 32'(m0_resp), 32'd0);
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    @(negedge clk);
    chk("arst_norsp", 32'(m0_rsp_valid | m1_rsp_valid), 32'd0);
    rst_n = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_addr = 7'h0A; m1_addr = 7'h0B;
    #1;
    chk("post_rst_rdy0", 32'(m0_req_ready), 32'd1);
    chk("post_rst_rdy1", 32'(m1_req_ready), 32'd0);
    @(negedge clk);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    chk("post_rst_addr", 32'(dmi_addr), 32'h0A);
    chk("post_rst_gnt",  32'(grant_id), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_dmi_arbiter.md
# jtag_dmi_arbiter

Shares the single DMI port of the RISC-V Debug Module between two requesters: requester 0 is the JTAG DTM, requester 1 is a secondary debug host (e.g. a memory-mapped debug bridge). It accepts one request at a time, forwards it to the Debug Module and routes the response back to the requester that issued it. Round-robin arbitration keeps either requester from starving the other. A timeout watchdog turns a hung DMI transaction into a failed response.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles from accept to target response; 0 disables the watchdog.
- clk  in  1  clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- mN_req_valid  in  1  (N=0,1) request valid.
- mN_req_ready  out  1  request accepted this cycle.
- mN_addr  in  DMI_ADDR_WIDTH  request address.
- mN_wdata  in  DMI_DATA_WIDTH  write data.
- mN_op  in  2  dmi_op_e.
- mN_rsp_valid  out  1  one-cycle response pulse.
- mN_rdata  out  DMI_DATA_WIDTH  response data.
- mN_resp  out  2  dmi_resp_e.
- dmi_req_valid  out  1  request to the Debug Module.
- dmi_req_ready  in  1  Debug Module accepts the request.
- dmi_addr, dmi_wdata, dmi_op  out  DMI_ADDR_WIDTH / DMI_DATA_WIDTH / 2  registered request payload.
- dmi_rsp_valid  in  1  Debug Module response valid.
- dmi_rdata, dmi_resp  in  DMI_DATA_WIDTH / 2  Debug Module response payload.
- dmi_abort  out  1  one-cycle pulse on watchdog expiry.
- busy  out  1  a transaction is outstanding.
- grant_id  out  1  owner of the current or most recent transaction.
- timeout_count  out  8  saturating count of timeouts.

## Operation
- FSM with three states: IDLE, REQ, RSP.
- IDLE:
  - Choose a winner among the valid requesters.
  - Assert the winner's mN_req_ready combinationally in that cycle.
  - Capture addr, wdata, op and grant_id into registers.
  - Clear the watchdog counter and go to REQ.
- Arbitration: rr_pref resets to 0. If both requesters are valid, the preferred one wins. After any grant, rr_pref becomes the non-granted id. If only one is valid, it wins regardless of rr_pref.
- REQ:
  - dmi_req_valid=1 with the registered payload.
  - The payload is held stable until dmi_req_ready.
  - On dmi_req_ready go to RSP.
- RSP:
  - On dmi_rsp_valid, register dmi_rdata and dmi_resp to the owner's mN_rdata and mN_resp.
  - Pulse the owner's mN_rsp_valid on the next cycle and go to IDLE.
  - The other requester's outputs do not change.
- A response arriving while in REQ is ignored, because the target must not respond before accepting the request.
- Watchdog:
  - The counter increments every cycle spent in REQ or RSP.
  - When the counter equals TIMEOUT_CYCLES-1 and no completion event (dmi_req_ready in REQ, or dmi_rsp_valid in RSP) occurs that cycle, the watchdog expires.
  - On expiry: the owner receives mN_resp=2'b10 (failed) and mN_rdata=0; dmi_abort pulses; timeout_count increments (saturating at 255); the FSM goes to IDLE.
  - If a completion event and expiry coincide, completion wins.
- NOP ops (op=0) are forwarded like any other op.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE, rr_pref=0, grant_id=0, counter=0, timeout_count=0.
  - All req_ready, rsp_valid, rdata, resp and dmi_* outputs are 0; dmi_abort=0.
- Best-case latency:
  - Cycle 0: accept.
  - Cycle 1: dmi_req_valid with dmi_req_ready.
  - Cycle 2: dmi_rsp_valid.
  - Cycle 3: mN_rsp_valid pulse. The FSM is in IDLE in cycle 3, so the next accept can happen in cycle 3.
- mN_req_ready is never asserted outside IDLE, so at most one transaction is outstanding.
- dmi_req_valid never drops before dmi_req_ready.
- mN_rdata and mN_resp hold their value until the owner's next response.
- Reset asserted mid-transaction: everything returns to reset values immediately and no response is delivered.

## Structure
- Use DMI_ADDR_WIDTH, DMI_DATA_WIDTH, dmi_op_e and dmi_resp_e from jtag_dmi_pkg.
- Add to jtag_dmi_pkg:
  - DMI_RESP_FAILED = 2'b10.
  - dmi_arb_state_e (IDLE/REQ/RSP).
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- Single module, no sub-modules. The round-robin pick is small enough to stay inline.

## Test plan
- m0 alone: read with addr=0x11; target readies in 1 cycle and responds with rdata=0xDEADBEEF, resp=0 two cycles after accept → m0_rsp_valid pulses 3 cycles after accept with 0xDEADBEEF/0; m1 outputs stay 0.
- Both requesters valid continuously for 4 transactions from reset → grants go 0,1,0,1 and each requester's responses carry its own addr-tagged data.
- Target holds dmi_req_ready low for 5 cycles → dmi_addr/wdata/op stay stable and dmi_req_valid stays high throughout; no mN_req_ready during that time.
- TIMEOUT_CYCLES=8, target never responds → at the 8th cycle after accept the owner gets resp=2'b10, rdata=0, dmi_abort pulses, timeout_count=1, busy drops.
- TIMEOUT_CYCLES=8, dmi_rsp_valid arrives exactly in the expiry cycle → normal response is delivered, no dmi_abort, timeout_count unchanged.
- rst_n asserted while in RSP → all outputs return to 0 asynchronously; after release the next request is accepted in IDLE with rr_pref=0.
